div_unit: RTL and testbench

Iterative 32-bit integer divider for the execute stage, alongside the combinational ALU that already provides `mul`. It computes quotient and remainder for `div`/`divu` with a radix-2 restoring algorithm, one quotient bit per cycle, and uses a start/busy/done handshake so the pipeline controller can stall while a division is in flight. Operand order and signedness selection match the ALU: `in1` is the dividend, `in2` the divisor, and `Sign` selects signed arithmetic.

---
 rtl/div_unit_if.sv | 31 +++
 rtl/div_unit.sv | 158 +++++++++++++++
 tb/tb_div_unit.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : div_unit_if
//  Brief    : Start/busy/done handshake and operand/result bus for div_unit.
//  Revision : 1.0 - initial release
// ============================================================================
interface div_unit_if;
    logic        start;
    logic        flush;
    logic        Sign;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    // Requester side: pipeline controller issuing divisions
    modport master (
        output start, flush, Sign, in1, in2,
        input  busy, done, quotient, remainder, div_by_zero
    );

    // Divider side
    modport slave (
        input  start, flush, Sign, in1, in2,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : div_unit
//  Brief    : Iterative 32-bit radix-2 restoring divider (div/divu), one
//             quotient bit per cycle, with start/busy/done handshake, flush
//             abort and a separate sign-fixup cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module div_unit (
    input  logic      clk,
    input  logic      rst_n,
    div_unit_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;       // partial remainder magnitude
    logic [31:0] dvd_q, dvd_d;       // dividend shifting out, quotient shifting in
    logic [31:0] dvs_q, dvs_d;       // divisor magnitude
    logic        sign_q, sign_d;     // signed operation
    logic        s1_q, s1_d;         // dividend was negative
    logic        s2_q, s2_d;         // divisor was negative
    logic        dz_q, dz_d;         // divisor was zero
    logic [31:0] quot_q, quot_d;
    logic [31:0] remo_q, remo_d;
    logic        dzo_q, dzo_d;
    logic        done_q, done_d;

    logic        w_accept;
    logic [31:0] w_abs1;
    logic [31:0] w_abs2;
    logic [32:0] w_shift;
    logic        w_ge;
    logic [31:0] w_diff;

    assign w_accept = (state_q == S_IDLE) && bus.start && !bus.flush;

    // Operand magnitudes; unsigned mode passes the raw bits through
    assign w_abs1 = (bus.Sign && bus.in1[31]) ? (32'd0 - bus.in1) : bus.in1;
    assign w_abs2 = (bus.Sign && bus.in2[31]) ? (32'd0 - bus.in2) : bus.in2;

    // The shifted remainder needs 33 bits; the restored/kept value always
    // fits back in 32 because it is strictly less than the divisor.
    assign w_shift = {rem_q, dvd_q[31]};
    assign w_ge    = (w_shift >= {1'b0, dvs_q});
    assign w_diff  = w_shift[31:0] - dvs_q;

    // Next-state logic: accept, iterate, sign fixup, flush abort
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        sign_d  = sign_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        dz_d    = dz_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dzo_d   = dzo_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    sign_d  = bus.Sign;
                    s1_d    = bus.in1[31];
                    s2_d    = bus.in2[31];
                    dz_d    = (bus.in2 == 32'd0);
                    dvd_d   = w_abs1;
                    dvs_d   = w_abs2;
                    rem_d   = 32'd0;
                    cnt_d   = 5'd0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d   = w_ge ? w_diff : w_shift[31:0];
                    dvd_d   = {dvd_q[30:0], w_ge};
                    cnt_d   = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!bus.flush) begin
                    // A zero divisor yields all-ones quotient and the
                    // original dividend as remainder; the magnitude loop
                    // already produces |in1| as remainder.
                    if (dz_q) begin
                        quot_d = 32'hFFFF_FFFF;
                    end else if (sign_q && (s1_q ^ s2_q)) begin
                        quot_d = 32'd0 - dvd_q;
                    end else begin
                        quot_d = dvd_q;
                    end
                    remo_d = (sign_q && s1_q) ? (32'd0 - rem_q) : rem_q;
                    dzo_d  = dz_q;
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            rem_q   <= 32'd0;
            dvd_q   <= 32'd0;
            dvs_q   <= 32'd0;
            sign_q  <= 1'b0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            dz_q    <= 1'b0;
            quot_q  <= 32'd0;
            remo_q  <= 32'd0;
            dzo_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            sign_q  <= sign_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            dz_q    <= dz_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dzo_q   <= dzo_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = remo_q;
    assign bus.div_by_zero = dzo_q;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_unit
//  Brief    : Self-checking bench for div_unit against an arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_div_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    div_unit_if ifc ();

    div_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_q;
    logic [31:0] last_r;
    logic        last_dz;

    // Reference: plain integer division with the divide-by-zero rule
    function automatic void ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r, output bit dz);
        longint sa;
        longint sb;
        dz = (b == 32'd0);
        if (dz) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Drive a start pulse from a negedge; returns at the negedge after E0
    task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b);
        ifc.Sign  = s;
        ifc.in1   = a;
        ifc.in2   = b;
        ifc.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.start = 1'b0;
    endtask

    // Count edges until done is seen (bounded); gaps counts busy-low cycles
    task automatic wait_done(input int maxc, output int lat, output int gaps);
        lat  = 0;
        gaps = 0;
        while (!ifc.done && lat < maxc) begin
            if (!ifc.busy) gaps++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        ifc.start = 1'b0;
        ifc.flush = 1'b0;
        ifc.Sign  = 1'b0;
        ifc.in1   = 32'd0;
        ifc.in2   = 32'd0;
        rst_n     = 1'b0;
        #12;
        n_checks++; if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", ifc.busy); end
        n_checks++; if (ifc.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", ifc.done); end
        n_checks++; if (ifc.quotient !== 32'd0) begin n_fail++; $display("FAIL reset_q got=%h exp=0", ifc.quotient); end
        n_checks++; if (ifc.remainder !== 32'd0) begin n_fail++; $display("FAIL reset_r got=%h exp=0", ifc.remainder); end
        n_checks++; if (ifc.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dz got=%b exp=0", ifc.div_by_zero); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned();
        int lat, gaps;
        issue(1'b0, 32'd100, 32'd7);
        wait_done(40, lat, gaps);
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL unsigned_latency got=%0d exp=33", lat); end
        n_checks++; if (gaps !== 0) begin n_fail++; $display("FAIL unsigned_busy_gaps got=%0d exp=0", gaps); end
        n_checks++; if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL unsigned_busy_at_done got=%b exp=0", ifc.busy); end
        n_checks++; if (ifc.quotient !== 32'd14) begin n_fail++; $display("FAIL unsigned_q got=%0d exp=14", ifc.quotient); end
        n_checks++; if (ifc.remainder !== 32'd2) begin n_fail++; $display("FAIL unsigned_r got=%0d exp=2", ifc.remainder); end
        n_checks++; if (ifc.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL unsigned_dz got=%b exp=0", ifc.div_by_zero); end
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (ifc.done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width got=%b exp=0", ifc.done); end
        n_checks++; if (ifc.quotient !== 32'd14) begin n_fail++; $display("FAIL q_hold got=%0d exp=14", ifc.quotient); end
    endtask

    task automatic test_signed();
        int lat, gaps;
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done(40, lat, gaps);
        n_checks++; if (ifc.quotient !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL signed_q got=%h exp=fffffffd", ifc.quotient); end
        n_checks++; if (ifc.remainder !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL signed_r got=%h exp=ffffffff", ifc.remainder); end
    endtask

    task automatic test_div_zero();
        int lat, gaps;
        issue(1'b0, 32'd1234, 32'd0);
        wait_done(40, lat, gaps);
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL dz_latency got=%0d exp=33", lat); end
        n_checks++; if (ifc.quotient !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dz_q got=%h exp=ffffffff", ifc.quotient); end
        n_checks++; if (ifc.remainder !== 32'd1234) begin n_fail++; $display("FAIL dz_r got=%0d exp=1234", ifc.remainder); end
        n_checks++; if (ifc.div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag got=%b exp=1", ifc.div_by_zero); end
        issue(1'b1, 32'hFFFF_FFFB, 32'd0);
        wait_done(40, lat, gaps);
        n_checks++; if (ifc.quotient !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dz_signed_q got=%h exp=ffffffff", ifc.quotient); end
        n_checks++; if (ifc.remainder !== 32'hFFFF_FFFB) begin n_fail++; $display("FAIL dz_signed_r got=%h exp=fffffffb", ifc.remainder); end
    endtask

    task automatic test_overflow();
        int lat, gaps;
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(40, lat, gaps);
        n_checks++; if (ifc.quotient !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_q got=%h exp=80000000", ifc.quotient); end
        n_checks++; if (ifc.remainder !== 32'd0) begin n_fail++; $display("FAIL ovf_r got=%h exp=0", ifc.remainder); end
        n_checks++; if (ifc.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL ovf_dz got=%b exp=0", ifc.div_by_zero); end
    endtask

    task automatic test_start_ignored();
        int lat, gaps;
        issue(1'b0, 32'd999, 32'd10);
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
        end
        ifc.Sign  = 1'b1;
        ifc.in1   = 32'd77;
        ifc.in2   = 32'd3;
        ifc.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.start = 1'b0;
        wait_done(40, lat, gaps);
        n_checks++; if (lat + 10 !== 33) begin n_fail++; $display("FAIL ignore_latency got=%0d exp=33", lat + 10); end
        n_checks++; if (ifc.quotient !== 32'd99) begin n_fail++; $display("FAIL ignore_q got=%0d exp=99", ifc.quotient); end
        n_checks++; if (ifc.remainder !== 32'd9) begin n_fail++; $display("FAIL ignore_r got=%0d exp=9", ifc.remainder); end
    endtask

    task automatic test_back_to_back();
        int lat, gaps;
        issue(1'b0, 32'd81, 32'd9);
        wait_done(40, lat, gaps);
        n_checks++; if (ifc.quotient !== 32'd9) begin n_fail++; $display("FAIL b2b_first_q got=%0d exp=9", ifc.quotient); end
        issue(1'b0, 32'd50, 32'd5);
        wait_done(40, lat, gaps);
        n_checks++; if (lat + 1 !== 34) begin n_fail++; $display("FAIL b2b_spacing got=%0d exp=34", lat + 1); end
        n_checks++; if (ifc.quotient !== 32'd10) begin n_fail++; $display("FAIL b2b_q got=%0d exp=10", ifc.quotient); end
        n_checks++; if (ifc.remainder !== 32'd0) begin n_fail++; $display("FAIL b2b_r got=%0d exp=0", ifc.remainder); end
        last_q  = 32'd10;
        last_r  = 32'd0;
        last_dz = 1'b0;
    endtask

    task automatic test_flush();
        int seen;
        issue(1'b0, 32'd1000, 32'd3);
        repeat (19) begin
            @(posedge clk);
            @(negedge clk);
        end
        ifc.flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.flush = 1'b0;
        n_checks++; if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got=%b exp=0", ifc.busy); end
        seen = 0;
        repeat (40) begin
            if (ifc.done) seen++;
            @(posedge clk);
            @(negedge clk);
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL flush_no_done got=%0d exp=0", seen); end
        n_checks++; if (ifc.quotient !== last_q) begin n_fail++; $display("FAIL flush_q_hold got=%h exp=%h", ifc.quotient, last_q); end
        n_checks++; if (ifc.remainder !== last_r) begin n_fail++; $display("FAIL flush_r_hold got=%h exp=%h", ifc.remainder, last_r); end
        n_checks++; if (ifc.div_by_zero !== last_dz) begin n_fail++; $display("FAIL flush_dz_hold got=%b exp=%b", ifc.div_by_zero, last_dz); end
        // flush together with start while idle: nothing accepted
        ifc.in1   = 32'd8;
        ifc.in2   = 32'd2;
        ifc.start = 1'b1;
        ifc.flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.start = 1'b0;
        ifc.flush = 1'b0;
        n_checks++; if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL flush_start_idle_busy got=%b exp=0", ifc.busy); end
    endtask

    task automatic test_async_reset();
        issue(1'b1, 32'hFFFF_FF00, 32'd7);
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy got=%b exp=0", ifc.busy); end
        n_checks++; if (ifc.done !== 1'b0) begin n_fail++; $display("FAIL areset_done got=%b exp=0", ifc.done); end
        n_checks++; if (ifc.quotient !== 32'd0) begin n_fail++; $display("FAIL areset_q got=%h exp=0", ifc.quotient); end
        n_checks++; if (ifc.remainder !== 32'd0) begin n_fail++; $display("FAIL areset_r got=%h exp=0", ifc.remainder); end
        n_checks++; if (ifc.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL areset_dz got=%b exp=0", ifc.div_by_zero); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        int          lat, gaps, sel;
        bit          s;
        logic [31:0] a, b, eq, er;
        bit          edz;
        for (int i = 0; i < 2000; i++) begin
            s   = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            case (sel)
                0: b = 32'd1;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'd0;
                3: a = b;
                4: b = 32'd0;
                5: b = 32'($urandom_range(1, 255));
                6: begin a = 32'h8000_0000; b = 32'($urandom_range(0, 3)) - 32'd1; end
                default: ;
            endcase
            ref_div(s, a, b, eq, er, edz);
            issue(s, a, b);
            wait_done(40, lat, gaps);
            n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL rand_latency s=%0d a=%h b=%h got=%0d exp=33", s, a, b, lat); end
            n_checks++; if (ifc.quotient !== eq) begin n_fail++; $display("FAIL rand_q s=%0d a=%h b=%h got=%h exp=%h", s, a, b, ifc.quotient, eq); end
            n_checks++; if (ifc.remainder !== er) begin n_fail++; $display("FAIL rand_r s=%0d a=%h b=%h got=%h exp=%h", s, a, b, ifc.remainder, er); end
            n_checks++; if (ifc.div_by_zero !== edz) begin n_fail++; $display("FAIL rand_dz s=%0d a=%h b=%h got=%b exp=%b", s, a, b, ifc.div_by_zero, edz); end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_start_ignored();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
